// File: rtl/capture_sequencer.sv
// -----------------------------------------------------------------------------
// capture_sequencer
//
// Multi-camera capture controller. After reset it runs camera init, retrying
// on timeout, then arbitrates per-camera photo and send requests. Photo
// requests always beat send requests; cameras are served round-robin. Each
// take grant issues a burst of photos. Each INIT/PHOTO/SEND operation is
// guarded by a timeout. A failure latches a sticky error code.
//
// Optional feature (macro CAPTURE_SEQ_AUTO_SEND_EN):
//   When defined, the final photo of a burst chains directly into a send for
//   the same camera. When undefined, the sequencer returns to WAIT.
//
// Ports:
//   clock       system clock
//   reset       synchronous, active-high reset
//   take_photo  per-camera photo request (level)
//   send_image  per-camera send request (level)
//   burst_len   photos per take grant, 0 treated as 1
//   done_init   init complete pulse
//   done_take   one photo complete pulse
//   done_send   send complete pulse
//   init        init command, one-cycle pulse
//   take        one-hot photo command, one-cycle pulse
//   send        one-hot send command, one-cycle pulse
//   busy        operation in progress (low in WAIT and FAULT)
//   photo_idx   index of current photo in burst
//   error       sticky fault flag
//   err_code    00 none, 01 init fail, 10 take timeout, 11 send timeout
// -----------------------------------------------------------------------------
module capture_sequencer #(
    parameter int NUM_CAMS     = 2,
    parameter int CNT_W        = 4,
    parameter int TIMEOUT      = 1000,
    parameter int INIT_RETRIES = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_CAMS-1:0] take_photo,
    input  logic [NUM_CAMS-1:0] send_image,
    input  logic [CNT_W-1:0]    burst_len,
    input  logic                done_init,
    input  logic                done_take,
    input  logic                done_send,
    output logic                init,
    output logic [NUM_CAMS-1:0] take,
    output logic [NUM_CAMS-1:0] send,
    output logic                busy,
    output logic [CNT_W-1:0]    photo_idx,
    output logic                error,
    output logic [1:0]          err_code
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int CAM_W = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1;
    localparam int RTY_W = (INIT_RETRIES > 0) ? $clog2(INIT_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        ST_START,
        ST_INIT,
        ST_WAIT,
        ST_PHOTO,
        ST_SEND,
        ST_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [CAM_W-1:0]   cam_q, cam_d;
    logic [CNT_W-1:0]   burst_q, burst_d;
    logic [CAM_W-1:0]   rr_q, rr_d;

    logic                init_d;
    logic [NUM_CAMS-1:0] take_d, send_d;
    logic                busy_d;
    logic [CNT_W-1:0]    idx_d;
    logic                error_d;
    logic [1:0]          err_d;

    logic                take_found, send_found;
    logic [CAM_W-1:0]    take_cam, send_cam;
    logic [CAM_W:0]      sum;

    function automatic logic [NUM_CAMS-1:0] onehot(input logic [CAM_W-1:0] c);
        logic [NUM_CAMS-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    function automatic logic [CAM_W-1:0] next_cam(input logic [CAM_W-1:0] c);
        logic [CAM_W:0] n;
        n = {1'b0, c} + 1'b1;
        if (n >= (CAM_W + 1)'(NUM_CAMS)) n = '0;
        return n[CAM_W-1:0];
    endfunction

    // Round-robin search starting at rr_q. The sum never exceeds
    // 2*NUM_CAMS-2, so a single conditional subtract gives the modulo.
    always_comb begin
        take_found = 1'b0;
        send_found = 1'b0;
        take_cam   = '0;
        send_cam   = '0;
        sum        = '0;
        for (int unsigned i = 0; i < NUM_CAMS; i++) begin
            sum = {1'b0, rr_q} + (CAM_W + 1)'(i);
            if (sum >= (CAM_W + 1)'(NUM_CAMS)) sum = sum - (CAM_W + 1)'(NUM_CAMS);
            if (!take_found && take_photo[sum[CAM_W-1:0]]) begin
                take_found = 1'b1;
                take_cam   = sum[CAM_W-1:0];
            end
            if (!send_found && send_image[sum[CAM_W-1:0]]) begin
                send_found = 1'b1;
                send_cam   = sum[CAM_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        cam_d   = cam_q;
        burst_d = burst_q;
        rr_d    = rr_q;
        init_d  = 1'b0;
        take_d  = '0;
        send_d  = '0;
        idx_d   = photo_idx;
        error_d = error;
        err_d   = err_code;

        case (state_q)
            ST_START: begin
                state_d = ST_INIT;
                init_d  = 1'b1;
                timer_d = TMR_W'(TIMEOUT);
            end
            ST_INIT: begin
                if (done_init) begin
                    state_d = ST_WAIT;
                    retry_d = '0;
                end else if (timer_q == '0) begin
                    if (retry_q < RTY_W'(INIT_RETRIES)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_FAULT;
                        error_d = 1'b1;
                        err_d   = 2'b01;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (take_found) begin
                    cam_d   = take_cam;
                    burst_d = (burst_len == '0) ? CNT_W'(1) : burst_len;
                    idx_d   = '0;
                    rr_d    = next_cam(take_cam);
                    take_d  = onehot(take_cam);
                    timer_d = TMR_W'(TIMEOUT);
                    state_d = ST_PHOTO;
                end else if (send_found) begin
                    cam_d   = send_cam;
                    burst_d = (burst_len == '0) ? CNT_W'(1) : burst_len;
                    idx_d   = '0;
                    rr_d    = next_cam(send_cam);
                    send_d  = onehot(send_cam);
                    timer_d = TMR_W'(TIMEOUT);
                    state_d = ST_SEND;
                end
            end
            ST_PHOTO: begin
                if (done_take) begin
                    if (({1'b0, photo_idx} + 1'b1) < {1'b0, burst_q}) begin
                        idx_d   = photo_idx + 1'b1;
                        take_d  = onehot(cam_q);
                        timer_d = TMR_W'(TIMEOUT);
                    end else begin
`ifdef CAPTURE_SEQ_AUTO_SEND_EN
                        state_d = ST_SEND;
                        send_d  = onehot(cam_q);
                        timer_d = TMR_W'(TIMEOUT);
`else
                        state_d = ST_WAIT;
`endif
                    end
                end else if (timer_q == '0) begin
                    state_d = ST_FAULT;
                    error_d = 1'b1;
                    err_d   = 2'b10;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_SEND: begin
                if (done_send) begin
                    state_d = ST_WAIT;
                end else if (timer_q == '0) begin
                    state_d = ST_FAULT;
                    error_d = 1'b1;
                    err_d   = 2'b11;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_FAULT: begin
                error_d = 1'b1;
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        // busy is registered from the next state so it tracks the state register
        busy_d = !((state_d == ST_WAIT) || (state_d == ST_FAULT));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_START;
            timer_q   <= '0;
            retry_q   <= '0;
            cam_q     <= '0;
            burst_q   <= '0;
            rr_q      <= '0;
            init      <= 1'b0;
            take      <= '0;
            send      <= '0;
            busy      <= 1'b1;
            photo_idx <= '0;
            error     <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            cam_q     <= cam_d;
            burst_q   <= burst_d;
            rr_q      <= rr_d;
            init      <= init_d;
            take      <= take_d;
            send      <= send_d;
            busy      <= busy_d;
            photo_idx <= idx_d;
            error     <= error_d;
            err_code  <= err_d;
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// -----------------------------------------------------------------------------
// tb_capture_sequencer
//
// Scoreboarded bench for capture_sequencer (NUM_CAMS=2, TIMEOUT=8,
// INIT_RETRIES=3). The driver predicts every command pulse (kind, camera,
// photo index, cycle) from the protocol rules and queues it. A monitor pops
// and compares whenever the DUT emits init/take/send. Honours
// CAPTURE_SEQ_AUTO_SEND_EN.
// -----------------------------------------------------------------------------
module tb_capture_sequencer;

    localparam int NC = 2;
    localparam int CW = 4;
    localparam int TO = 8;
    localparam int IR = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NC-1:0] take_photo = '0;
    logic [NC-1:0] send_image = '0;
    logic [CW-1:0] burst_len = '0;
    logic          done_init = 1'b0;
    logic          done_take = 1'b0;
    logic          done_send = 1'b0;
    logic          init;
    logic [NC-1:0] take;
    logic [NC-1:0] send;
    logic          busy;
    logic [CW-1:0] photo_idx;
    logic          error;
    logic [1:0]    err_code;

    capture_sequencer #(
        .NUM_CAMS    (NC),
        .CNT_W       (CW),
        .TIMEOUT     (TO),
        .INIT_RETRIES(IR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .take_photo(take_photo),
        .send_image(send_image),
        .burst_len (burst_len),
        .done_init (done_init),
        .done_take (done_take),
        .done_send (done_send),
        .init      (init),
        .take      (take),
        .send      (send),
        .busy      (busy),
        .photo_idx (photo_idx),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // kind: 0 init, 1 take, 2 send
    typedef struct {
        int kind;
        int cam;
        int idx;
        int at;
    } ev_t;

    ev_t expq[$];
    int  checks = 0;
    int  errors = 0;
    int  rr     = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int pick(input logic [NC-1:0] m, input int start);
        for (int i = 0; i < NC; i++) begin
            int c;
            c = (start + i) % NC;
            if (m[c]) return c;
        end
        return 0;
    endfunction

    function automatic int dly();
        if ($urandom_range(0, 3) == 0) return TO;
        return $urandom_range(0, TO);
    endfunction

    // Monitor: every command pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        ev_t e;
        int  ev;
        if (init || take != '0 || send != '0) begin
            if (expq.size() == 0) begin
                chk("unexpected_pulse", int'({init, take, send}), 0);
            end else begin
                e = expq.pop_front();
                case (e.kind)
                    0:       ev = 1 << (2 * NC);
                    1:       ev = 1 << (NC + e.cam);
                    default: ev = 1 << e.cam;
                endcase
                chk("pulse_vec", int'({init, take, send}), ev);
                chk("pulse_cycle", cyc, e.at);
                if (e.kind == 1) chk("photo_idx", int'(photo_idx), e.idx);
            end
        end
    end

    // phase: 0 init, 1 wait-idle, 2 photo, 3 send, 4 fault
    // Only dones the current state ignores are randomised.
    task automatic noise(input int phase, input bit hold);
        done_init = (phase != 0) && ($urandom_range(0, 3) == 0);
        done_take = (phase != 2) && ($urandom_range(0, 3) == 0);
        done_send = (phase != 3) && ($urandom_range(0, 3) == 0);
        if (!hold && phase != 1) begin
            take_photo = NC'($urandom_range(0, 3));
            send_image = NC'($urandom_range(0, 3));
        end
        burst_len = CW'($urandom_range(0, 5));
    endtask

    task automatic quiet(input bit hold);
        done_init = 1'b0;
        done_take = 1'b0;
        done_send = 1'b0;
        if (!hold) begin
            take_photo = '0;
            send_image = '0;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        quiet(0);
        step();
        chk("rst_busy", int'(busy), 1);
        chk("rst_init", int'(init), 0);
        chk("rst_take_send", int'({take, send}), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_photo_idx", int'(photo_idx), 0);
        step();
        step();
        rr = 0;
    endtask

    // Release reset; the first 'fails' init attempts time out, then done_init.
    task automatic release_and_init(input int fails);
        int p, d;
        reset = 1'b0;
        p = cyc + 1;
        expq.push_back(ev_t'{0, 0, 0, p});
        step();
        for (int f = 1; f <= fails; f++) begin
            repeat (TO + 2) begin
                noise(0, 0);
                step();
            end
            expq.push_back(ev_t'{0, 0, 0, p + f * (TO + 2)});
        end
        d = dly();
        repeat (d) begin
            noise(0, 0);
            step();
        end
        noise(0, 0);
        done_init = 1'b1;
        chk("busy_in_init", int'(busy), 1);
        step();
        quiet(0);
        chk("init_busy", int'(busy), 0);
        chk("init_error", int'(error), 0);
        chk("init_err_code", int'(err_code), 0);
    endtask

    task automatic send_wait(input bit hold);
        int d;
        d = dly();
        repeat (d) begin
            noise(3, hold);
            step();
        end
        noise(3, hold);
        done_send = 1'b1;
        step();
        quiet(hold);
    endtask

    // Called in a WAIT cycle with requests driven; returns in the next WAIT cycle.
    task automatic serve(input bit hold);
        logic [NC-1:0] tm, sm;
        int  k, b, d;
        bit  is_take;
        tm = take_photo;
        sm = send_image;
        is_take = (tm != '0);
        k  = is_take ? pick(tm, rr) : pick(sm, rr);
        rr = (k + 1) % NC;
        b  = (burst_len == '0) ? 1 : int'(burst_len);
        expq.push_back(ev_t'{is_take ? 1 : 2, k, 0, cyc + 1});
        step();
        if (!hold) begin
            take_photo = '0;
            send_image = '0;
        end
        if (is_take) begin
            for (int j = 0; j < b; j++) begin
                d = dly();
                repeat (d) begin
                    noise(2, hold);
                    step();
                end
                noise(2, hold);
                done_take = 1'b1;
                step();
                quiet(hold);
                if (j < b - 1) expq.push_back(ev_t'{1, k, j + 1, cyc});
            end
`ifdef CAPTURE_SEQ_AUTO_SEND_EN
            expq.push_back(ev_t'{2, k, 0, cyc});
            send_wait(hold);
`endif
        end else begin
            send_wait(hold);
        end
        chk("wait_busy", int'(busy), 0);
        chk("wait_error", int'(error), 0);
        if (is_take) chk("idx_hold", int'(photo_idx), b - 1);
    endtask

    // Grant one operation and never complete it: expect the timeout fault.
    task automatic fault_op(input bit is_take);
        int k, p;
        quiet(0);
        k = $urandom_range(0, NC - 1);
        if (is_take) take_photo = NC'(1 << k);
        else         send_image = NC'(1 << k);
        burst_len = CW'($urandom_range(0, 5));
        rr = (k + 1) % NC;
        p  = cyc + 1;
        expq.push_back(ev_t'{is_take ? 1 : 2, k, 0, p});
        step();
        quiet(0);
        while (cyc <= p + TO) begin
            noise(is_take ? 2 : 3, 0);
            if (cyc == p + TO) chk("pre_fault_error", int'(error), 0);
            step();
        end
        quiet(0);
        chk("fault_error", int'(error), 1);
        chk("fault_code", int'(err_code), is_take ? 2 : 3);
        chk("fault_busy", int'(busy), 0);
        repeat (5) begin
            noise(4, 0);
            step();
        end
        quiet(0);
        chk("fault_sticky", int'(error), 1);
    endtask

    task automatic random_ops(input int n);
        logic [NC-1:0] tm, sm;
        repeat (n) begin
            repeat ($urandom_range(0, 3)) begin
                noise(1, 0);
                step();
            end
            quiet(0);
            do begin
                tm = NC'($urandom_range(0, 3));
                sm = NC'($urandom_range(0, 3));
            end while (tm == '0 && sm == '0);
            take_photo = tm;
            send_image = sm;
            burst_len  = CW'($urandom_range(0, 5));
            serve(0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, fault_at, k;

        // power-up init
        apply_reset();
        release_and_init(0);

        // held requests on both cameras: grants alternate, takes beat sends
        quiet(0);
        take_photo = 2'b11;
        send_image = 2'b01;
        burst_len  = 1;
        serve(1);
        serve(1);
        serve(0);

        random_ops(30);

        // photo timeout, then init with one retry
        fault_op(1);
        apply_reset();
        release_and_init(1);
        random_ops(10);

        // send timeout, then init with two retries
        fault_op(0);
        apply_reset();
        release_and_init(2);

        // three-photo burst on camera 1
        quiet(0);
        take_photo = 2'b10;
        burst_len  = 3;
        serve(0);

        // reset in the middle of a send
        quiet(0);
        k = $urandom_range(0, NC - 1);
        send_image = NC'(1 << k);
        rr = (k + 1) % NC;
        expq.push_back(ev_t'{2, k, 0, cyc + 1});
        step();
        quiet(0);
        repeat ($urandom_range(1, TO - 1)) begin
            noise(3, 0);
            step();
        end
        reset = 1'b1;
        quiet(0);
        step();
        chk("midrst_send", int'(send), 0);
        chk("midrst_error", int'(error), 0);
        chk("midrst_idx", int'(photo_idx), 0);
        chk("midrst_busy", int'(busy), 1);
        done_send = 1'b1;
        step();
        step();
        done_send = 1'b0;
        rr = 0;
        release_and_init(0);
        random_ops(5);

        // init never completes: four attempts then init fault
        apply_reset();
        reset = 1'b0;
        p = cyc + 1;
        expq.push_back(ev_t'{0, 0, 0, p});
        step();
        for (int a = 1; a <= IR; a++) begin
            repeat (TO + 2) begin
                noise(0, 0);
                step();
            end
            expq.push_back(ev_t'{0, 0, 0, p + a * (TO + 2)});
        end
        fault_at = p + IR * (TO + 2) + TO + 1;
        while (cyc < fault_at) begin
            noise(0, 0);
            if (cyc == fault_at - 1) chk("initfail_pre_error", int'(error), 0);
            step();
        end
        quiet(0);
        chk("initfail_error", int'(error), 1);
        chk("initfail_code", int'(err_code), 1);
        chk("initfail_busy", int'(busy), 0);
        repeat (5) begin
            noise(4, 0);
            step();
        end
        quiet(0);
        chk("initfail_sticky", int'(err_code), 1);

        step();
        chk("queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
